// File: rtl/lc3b_types.sv
// Shared LC-3b types for the decode/execute interlock: opcodes, register
// indices, interlock FSM states and default bubble counts.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic {ILK_RUN, ILK_STALL} lc3b_ilk_state;

  // LDR/LDB data is forwardable after one bubble; LDI needs a second memory
  // access, so it needs one more.
  localparam int unsigned DEFAULT_LOAD_BUBBLES     = 1;
  localparam int unsigned DEFAULT_INDIRECT_BUBBLES = 2;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the ID instruction and a
// load sitting in EX, plus selection of how many bubbles that load needs.
module hazard_detect
  import lc3b_types::*;
#(
  parameter int unsigned LOAD_BUBBLES     = DEFAULT_LOAD_BUBBLES,
  parameter int unsigned INDIRECT_BUBBLES = DEFAULT_INDIRECT_BUBBLES
) (
  input  logic       id_valid,
  input  lc3b_reg    id_sr1,
  input  lc3b_reg    id_sr2,
  input  logic       id_uses_sr1,
  input  logic       id_uses_sr2,
  input  logic       id_imm,
  input  logic       ex_valid,
  input  lc3b_opcode ex_opcode,
  input  lc3b_reg    ex_dest,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  output logic       hazard,
  output logic [1:0] n_bubbles
);

  // A source matches only if it is really read; SR2 is ignored in immediate mode.
  always_comb begin
    hazard = id_valid && ex_valid && ex_mem_read && ex_reg_write &&
             ((id_uses_sr1 && (id_sr1 == ex_dest)) ||
              (id_uses_sr2 && !id_imm && (id_sr2 == ex_dest)));
  end

  // Indirect loads need the longer interlock.
  always_comb begin
    n_bubbles = (ex_opcode == op_ldi) ? 2'(INDIRECT_BUBBLES) : 2'(LOAD_BUBBLES);
  end

endmodule

// File: rtl/id_exec_interlock.sv
// ID/EX pipeline register with load-use interlock. Holds on freeze, clears
// on flush, and inserts bubbles behind loads whose result ID needs.
module id_exec_interlock
  import lc3b_types::*;
#(
  parameter int unsigned LOAD_BUBBLES     = DEFAULT_LOAD_BUBBLES,
  parameter int unsigned INDIRECT_BUBBLES = DEFAULT_INDIRECT_BUBBLES,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  lc3b_opcode       id_opcode,
  input  lc3b_reg          id_sr1,
  input  lc3b_reg          id_sr2,
  input  lc3b_reg          id_dest,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic             id_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             freeze,
  input  logic             flush,
  output logic             ex_valid,
  output lc3b_opcode       ex_opcode,
  output lc3b_reg          sr1_exec,
  output lc3b_reg          sr2_exec,
  output lc3b_reg          ex_dest,
  output logic             exec_imm,
  output logic             exec_mem_read,
  output logic             exec_mem_write,
  output logic             ex_reg_write,
  output logic             id_stall,
  output logic [CNT_W-1:0] bubble_count
);

  lc3b_ilk_state state_reg;
  logic [1:0]    remain_reg;
  logic          hazard;
  logic [1:0]    n_bubbles;

  hazard_detect #(
    .LOAD_BUBBLES    (LOAD_BUBBLES),
    .INDIRECT_BUBBLES(INDIRECT_BUBBLES)
  ) u_hazard (
    .id_valid    (id_valid),
    .id_sr1      (id_sr1),
    .id_sr2      (id_sr2),
    .id_uses_sr1 (id_uses_sr1),
    .id_uses_sr2 (id_uses_sr2),
    .id_imm      (id_imm),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_dest     (ex_dest),
    .ex_mem_read (exec_mem_read),
    .ex_reg_write(ex_reg_write),
    .hazard      (hazard),
    .n_bubbles   (n_bubbles)
  );

  // Front end holds on freeze or any interlock bubble; a flush overrides the
  // interlock because the ID instruction is being killed anyway.
  always_comb begin
    id_stall = rst_n && (freeze || (!flush && ((state_reg == ILK_STALL) || hazard)));
  end

  // EX register, interlock FSM and bubble statistics; freeze holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_opcode      <= op_br;
      sr1_exec       <= '0;
      sr2_exec       <= '0;
      ex_dest        <= '0;
      exec_imm       <= 1'b0;
      exec_mem_read  <= 1'b0;
      exec_mem_write <= 1'b0;
      ex_reg_write   <= 1'b0;
      state_reg      <= ILK_RUN;
      remain_reg     <= 2'd0;
      bubble_count   <= '0;
    end else if (!freeze) begin
      if (flush) begin
        ex_valid       <= 1'b0;
        exec_imm       <= 1'b0;
        exec_mem_read  <= 1'b0;
        exec_mem_write <= 1'b0;
        ex_reg_write   <= 1'b0;
        state_reg      <= ILK_RUN;
        remain_reg     <= 2'd0;
      end else if ((state_reg == ILK_STALL) || hazard) begin
        ex_valid       <= 1'b0;
        exec_imm       <= 1'b0;
        exec_mem_read  <= 1'b0;
        exec_mem_write <= 1'b0;
        ex_reg_write   <= 1'b0;
        if (bubble_count != '1) begin
          bubble_count <= bubble_count + CNT_W'(1);
        end
        if (state_reg == ILK_STALL) begin
          remain_reg <= remain_reg - 2'd1;
          if (remain_reg == 2'd1) begin
            state_reg <= ILK_RUN;
          end
        end else if (n_bubbles > 2'd1) begin
          remain_reg <= n_bubbles - 2'd1;
          state_reg  <= ILK_STALL;
        end
      end else begin
        ex_valid       <= id_valid;
        ex_opcode      <= id_opcode;
        sr1_exec       <= id_sr1;
        sr2_exec       <= id_sr2;
        ex_dest        <= id_dest;
        exec_imm       <= id_imm && id_valid;
        exec_mem_read  <= id_mem_read && id_valid;
        exec_mem_write <= id_mem_write && id_valid;
        ex_reg_write   <= id_reg_write && id_valid;
      end
    end
  end

endmodule

// File: tb/tb_id_exec_interlock.sv
// Self-checking bench for id_exec_interlock: expected EX contents are queued
// as each ID instruction is driven and compared one cycle later.
module tb_id_exec_interlock;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_n3;
  logic       id_valid;
  lc3b_opcode id_opcode;
  lc3b_reg    id_sr1, id_sr2, id_dest;
  logic       id_uses_sr1, id_uses_sr2, id_imm;
  logic       id_reg_write, id_mem_read, id_mem_write;
  logic       freeze, flush;

  logic        ex_valid;
  lc3b_opcode  ex_opcode;
  lc3b_reg     sr1_exec, sr2_exec, ex_dest;
  logic        exec_imm, exec_mem_read, exec_mem_write, ex_reg_write, id_stall;
  logic [15:0] bubble_count;

  logic       ex_valid3;
  lc3b_opcode ex_opcode3;
  lc3b_reg    sr1_exec3, sr2_exec3, ex_dest3;
  logic       exec_imm3, exec_mem_read3, exec_mem_write3, ex_reg_write3, id_stall3;
  logic [1:0] bubble_count3;

  id_exec_interlock u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_dest(id_dest),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .freeze(freeze), .flush(flush), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .sr1_exec(sr1_exec), .sr2_exec(sr2_exec), .ex_dest(ex_dest),
    .exec_imm(exec_imm), .exec_mem_read(exec_mem_read), .exec_mem_write(exec_mem_write),
    .ex_reg_write(ex_reg_write), .id_stall(id_stall), .bubble_count(bubble_count)
  );

  // Three-bubble LDI interlock with a 2-bit counter to reach saturation quickly.
  id_exec_interlock #(.LOAD_BUBBLES(1), .INDIRECT_BUBBLES(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_dest(id_dest),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .freeze(freeze), .flush(flush), .ex_valid(ex_valid3), .ex_opcode(ex_opcode3),
    .sr1_exec(sr1_exec3), .sr2_exec(sr2_exec3), .ex_dest(ex_dest3),
    .exec_imm(exec_imm3), .exec_mem_read(exec_mem_read3), .exec_mem_write(exec_mem_write3),
    .ex_reg_write(ex_reg_write3), .id_stall(id_stall3), .bubble_count(bubble_count3)
  );

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic [2:0] sr1, sr2, dest;
    logic       imm, mr, mw, rw;
  } ex_t;

  // full=0 marks a bubble: only valid and the control bits are meaningful.
  typedef struct packed {
    logic full;
    ex_t  ex;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic ex_t obs();
    ex_t r;
    r.valid = ex_valid;  r.op = ex_opcode;  r.sr1 = sr1_exec;  r.sr2 = sr2_exec;
    r.dest = ex_dest;    r.imm = exec_imm;  r.mr = exec_mem_read;
    r.mw = exec_mem_write;  r.rw = ex_reg_write;
    return r;
  endfunction

  function automatic ex_t mk(logic v, lc3b_opcode op, lc3b_reg s1, lc3b_reg s2, lc3b_reg d,
                             logic imm, logic mr, logic mw, logic rw);
    ex_t r;
    r.valid = v;  r.op = op;  r.sr1 = s1;  r.sr2 = s2;  r.dest = d;
    r.imm = imm;  r.mr = mr;  r.mw = mw;  r.rw = rw;
    return r;
  endfunction

  task automatic drive_id(input logic v, input lc3b_opcode op, input lc3b_reg s1,
                          input lc3b_reg s2, input lc3b_reg d, input logic u1, input logic u2,
                          input logic imm, input logic rw, input logic mr, input logic mw);
    id_valid = v;  id_opcode = op;  id_sr1 = s1;  id_sr2 = s2;  id_dest = d;
    id_uses_sr1 = u1;  id_uses_sr2 = u2;  id_imm = imm;
    id_reg_write = rw;  id_mem_read = mr;  id_mem_write = mw;
  endtask

  task automatic drive_idle();
    drive_id(1'b0, op_br, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ex_t o;
    rst_n = 1'b0;  rst_n3 = 1'b0;
    drive_idle();
    freeze = 1'b1;  flush = 1'b0;
    #12;
    o = obs();
    n_checks++;
    if (o !== mk(1'b0, op_br, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;  $display("FAIL reset_ex: got %h required %h", o, mk(1'b0, op_br, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", id_stall); end
    n_checks++;
    if (bubble_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", bubble_count); end
    freeze = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;  rst_n3 = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    exp_t e;  ex_t o;
    drive_id(1'b1, op_ldr, 3'd2, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({1'b1, mk(1'b1, op_ldr, 3'd2, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL lu_ldr_enter: got %h required %h", o, e.ex);
    end
    drive_id(1'b1, op_add, 3'd1, 3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b required 1", id_stall); end
    exp_q.push_back({1'b0, mk(1'b0, op_br, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL lu_bubble: got %h required %h", o, e.ex);
    end
    n_checks++;
    if (bubble_count !== 16'd1) begin n_fail++; $display("FAIL lu_count: got %0d required 1", bubble_count); end
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b required 0", id_stall); end
    exp_q.push_back({1'b1, mk(1'b1, op_add, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL lu_add_enter: got %h required %h", o, e.ex);
    end
  endtask

  task automatic test_ldi();
    exp_t e;  ex_t o;
    drive_id(1'b1, op_ldi, 3'd3, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({1'b1, mk(1'b1, op_ldi, 3'd3, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL ldi_enter: got %h required %h", o, e.ex);
    end
    drive_id(1'b1, op_and, 3'd6, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (id_stall !== 1'b1) begin n_fail++; $display("FAIL ldi_stall%0d: got %b required 1", i, id_stall); end
      exp_q.push_back({1'b0, mk(1'b0, op_br, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
      step();
      e = exp_q.pop_front();  o = obs();  n_checks++;
      if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
        n_fail++;  $display("FAIL ldi_bubble%0d: got %h required %h", i, o, e.ex);
      end
      n_checks++;
      if (bubble_count !== 16'(2 + i)) begin n_fail++; $display("FAIL ldi_count%0d: got %0d required %0d", i, bubble_count, 2 + i); end
    end
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL ldi_release: got %b required 0", id_stall); end
    exp_q.push_back({1'b1, mk(1'b1, op_and, 3'd6, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL ldi_and_enter: got %h required %h", o, e.ex);
    end
  endtask

  task automatic test_imm_and_store();
    exp_t e;  ex_t o;
    drive_id(1'b1, op_ldr, 3'd2, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({1'b1, mk(1'b1, op_ldr, 3'd2, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL imm_ldr_enter: got %h required %h", o, e.ex);
    end
    // SR2 field matches the load destination but the operand is an immediate.
    drive_id(1'b1, op_add, 3'd3, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL imm_no_stall: got %b required 0", id_stall); end
    exp_q.push_back({1'b1, mk(1'b1, op_add, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL imm_add_enter: got %h required %h", o, e.ex);
    end
    drive_id(1'b1, op_str, 3'd5, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({1'b1, mk(1'b1, op_str, 3'd5, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL st_str_enter: got %h required %h", o, e.ex);
    end
    drive_id(1'b1, op_add, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL st_no_stall: got %b required 0", id_stall); end
    exp_q.push_back({1'b1, mk(1'b1, op_add, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL st_add_enter: got %h required %h", o, e.ex);
    end
    n_checks++;
    if (bubble_count !== 16'd3) begin n_fail++; $display("FAIL imm_st_count: got %0d required 3", bubble_count); end
  endtask

  task automatic test_freeze();
    exp_t e;  ex_t o;
    drive_id(1'b1, op_ldr, 3'd2, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({1'b1, mk(1'b1, op_ldr, 3'd2, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL frz_ldr_enter: got %h required %h", o, e.ex);
    end
    drive_id(1'b1, op_add, 3'd1, 3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (id_stall !== 1'b1) begin n_fail++; $display("FAIL frz_stall%0d: got %b required 1", i, id_stall); end
      exp_q.push_back({1'b1, mk(1'b1, op_ldr, 3'd2, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1)});
      step();
      e = exp_q.pop_front();  o = obs();  n_checks++;
      if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
        n_fail++;  $display("FAIL frz_hold%0d: got %h required %h", i, o, e.ex);
      end
      n_checks++;
      if (bubble_count !== 16'd3) begin n_fail++; $display("FAIL frz_count%0d: got %0d required 3", i, bubble_count); end
    end
    freeze = 1'b0;
    #1;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL frz_thaw_stall: got %b required 1", id_stall); end
    exp_q.push_back({1'b0, mk(1'b0, op_br, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL frz_bubble: got %h required %h", o, e.ex);
    end
    n_checks++;
    if (bubble_count !== 16'd4) begin n_fail++; $display("FAIL frz_thaw_count: got %0d required 4", bubble_count); end
    exp_q.push_back({1'b1, mk(1'b1, op_add, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL frz_add_enter: got %h required %h", o, e.ex);
    end
  endtask

  task automatic test_flush();
    exp_t e;  ex_t o;
    drive_id(1'b1, op_ldi, 3'd3, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({1'b1, mk(1'b1, op_ldi, 3'd3, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL fl_ldi_enter: got %h required %h", o, e.ex);
    end
    drive_id(1'b1, op_and, 3'd6, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %b required 0", id_stall); end
    exp_q.push_back({1'b0, mk(1'b0, op_br, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL fl_bubble: got %h required %h", o, e.ex);
    end
    n_checks++;
    if (bubble_count !== 16'd4) begin n_fail++; $display("FAIL fl_count: got %0d required 4", bubble_count); end
    flush = 1'b0;
    #1;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL fl_run_state: got %b required 0", id_stall); end
    exp_q.push_back({1'b1, mk(1'b1, op_and, 3'd6, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1)});
    step();
    e = exp_q.pop_front();  o = obs();  n_checks++;
    if (e.full ? (o !== e.ex) : ({o.valid, o.imm, o.mr, o.mw, o.rw} !== {e.ex.valid, e.ex.imm, e.ex.mr, e.ex.mw, e.ex.rw})) begin
      n_fail++;  $display("FAIL fl_and_enter: got %h required %h", o, e.ex);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_idle();
    rst_n3 = 1'b0;
    #2;
    rst_n3 = 1'b1;
    drive_id(1'b1, op_ldi, 3'd3, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    n_checks++;
    if (ex_valid3 !== 1'b1) begin n_fail++; $display("FAIL r3_ldi_enter: got %b required 1", ex_valid3); end
    drive_id(1'b1, op_and, 3'd6, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bubble_count3 !== 2'(i + 1)) begin n_fail++; $display("FAIL r3_count%0d: got %0d required %0d", i, bubble_count3, i + 1); end
      n_checks++;
      if (id_stall3 !== (i < 2)) begin n_fail++; $display("FAIL r3_stall%0d: got %b required %b", i, id_stall3, (i < 2)); end
    end
    step();
    n_checks++;
    if (ex_valid3 !== 1'b1) begin n_fail++; $display("FAIL r3_and_enter: got %b required 1", ex_valid3); end
    drive_id(1'b1, op_ldi, 3'd3, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive_id(1'b1, op_and, 3'd6, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    n_checks++;
    if (bubble_count3 !== 2'd3) begin n_fail++; $display("FAIL r3_saturate: got %0d required 3", bubble_count3); end
    n_checks++;
    if (id_stall3 !== 1'b1) begin n_fail++; $display("FAIL r3_in_stall: got %b required 1", id_stall3); end
    #2;
    rst_n3 = 1'b0;
    #1;
    n_checks++;
    if ({ex_valid3, ex_opcode3, sr1_exec3, sr2_exec3, ex_dest3, exec_imm3, exec_mem_read3,
         exec_mem_write3, ex_reg_write3} !== 18'd0) begin
      n_fail++;
      $display("FAIL r3_async_ex: got %h required 0", {ex_valid3, ex_opcode3, sr1_exec3, sr2_exec3,
               ex_dest3, exec_imm3, exec_mem_read3, exec_mem_write3, ex_reg_write3});
    end
    n_checks++;
    if (bubble_count3 !== 2'd0) begin n_fail++; $display("FAIL r3_async_count: got %0d required 0", bubble_count3); end
    n_checks++;
    if (id_stall3 !== 1'b0) begin n_fail++; $display("FAIL r3_async_stall: got %b required 0", id_stall3); end
    #1;
    rst_n3 = 1'b1;
    #1;
    n_checks++;
    if (id_stall3 !== 1'b0) begin n_fail++; $display("FAIL r3_post_stall: got %b required 0", id_stall3); end
    step();
    n_checks++;
    if (ex_valid3 !== 1'b1 || sr2_exec3 !== 3'd4) begin
      n_fail++;  $display("FAIL r3_post_enter: got valid %b sr2 %0d required valid 1 sr2 4", ex_valid3, sr2_exec3);
    end
    n_checks++;
    if (bubble_count3 !== 2'd0) begin n_fail++; $display("FAIL r3_post_count: got %0d required 0", bubble_count3); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_ldi();
    test_imm_and_store();
    test_freeze();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
